key_pulse_array: RTL and testbench
==================================

# key_pulse_array

Parametrised, multi-channel key-press conditioner: synchronises N asynchronous key inputs, debounces each one, and emits a single-cycle `pulse` per debounced press. An optional auto-repeat feature is available. It sits between the board pushbuttons and the game/control FSMs, and replaces the single-key press detector used in earlier labs.

## Interface
- `N`, 4: number of independent key channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 4: consecutive disagreeing synced samples needed to accept a level change; must be ≥ 1.
- `REPEAT_DELAY`, 16: cycles from a press pulse to the first repeat pulse; must be ≥ `REPEAT_PERIOD`.
- `REPEAT_PERIOD`, 4: cycles between subsequent repeat pulses; must be ≥ 1.
- `ACTIVE_LOW`, 0: 1 = key inputs are inverted before synchronisation.

Ports:
- `Clock`  in  1  clock.
- `Reset`  in  1  reset; synchronous, active-high.
- `key`  in  N  raw asynchronous key levels.
- `pulse`  out  N  one-cycle press (and repeat) strobe per channel, registered.
- `held`  out  N  debounced key level per channel, registered.
- `any_pulse`  out  1  registered OR of all `pulse` bits, aligned with `pulse`.

## Operation
- Each channel runs independently. There is no cross-channel interaction except `any_pulse`.
- Synchroniser: a shift chain of `SYNC_STAGES` flops. `synced` is the last stage.
- Debounce counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1):
  - When `synced` == `held`, `cnt` <= 0.
  - Otherwise `cnt` increments.
  - When `cnt` == DEBOUNCE_CYCLES-1 and `synced` != `held`, then `held` <= `synced` and `cnt` <= 0.
- Channel FSM, with states RELEASED, HELD_DELAY and HELD_REPEAT:
  - RELEASED → HELD_DELAY on acceptance of a 0→1 change. `pulse` = 1 on that edge.
  - HELD_DELAY: repeat counter `rcnt` counts up. At `rcnt` == REPEAT_DELAY-1 it moves to HELD_REPEAT, `pulse` = 1, and `rcnt` <= 0.
  - HELD_REPEAT: at `rcnt` == REPEAT_PERIOD-1 it emits `pulse` and sets `rcnt` <= 0.
  - Any state → RELEASED on acceptance of a 1→0 change. No pulse is emitted on release, and `rcnt` is cleared.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change in `held` and no pulse.
- Reset values: `pulse` = 0, `held` = 0, `any_pulse` = 0, all sync flops 0, `cnt` = `rcnt` = 0, FSM = RELASED.
- Reset mid-operation: all state is cleared on the reset edge. A key still held when Reset deasserts is treated as a new press, and a fresh pulse follows after the normal latency.
- Simultaneous presses on several channels pulse in the same cycle, and `any_pulse` is high for that cycle.

## Timing
- Press latency: `key` is first sampled high at edge 1. `synced` is high after edge SYNC_STAGES. `held` and `pulse` go high after edge SYNC_STAGES+DEBOUNCE_CYCLES; with the defaults this is edge 6.
- `pulse` is high for exactly one cycle per event.
- Release latency equals press latency, measured to `held` falling.
- Repeat pulses fire REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
- Counters saturate by construction: they never exceed their terminal value, so there is no wrap-around.

## Configuration
- Macro: `KEY_PULSE_REPEAT_EN`.
  - Defined: auto-repeat exists as described above.
  - Undefined: the HELD_REPEAT state and `rcnt` are not built. HELD_DELAY is a terminal held state, and exactly one pulse is produced per debounced press.
- `REPEAT_*` parameters are accepted but ignored when the macro is undefined.

## Structure
- Package `key_pulse_pkg`: enum `key_state_t` (RELEASED, HELD_DELAY, HELD_REPEAT), plus default parameter constants.
- Sub-module `key_pulse_channel`: one channel containing the synchroniser, debounce counter and FSM, instantiated N times in a generate loop.
- Top level holds only the instances and the `any_pulse` register.

## Test plan
All scenarios use default parameters.
1. Reset held for 2 cycles with `key` = 0 → `pulse`, `held` and `any_pulse` are 0 throughout and after.
2. `key[0]` 0→1, held for 12 cycles → `pulse[0]` is high only between edges 6 and 7; `held[0]` is 1 from edge 6; no other channel toggles.
3. `key[1]` high for 3 cycles, then low → `held[1]` and `pulse[1]` stay 0.
4. `key[2]` and `key[3]` rise in the same cycle → `pulse[2]`, `pulse[3]` and `any_pulse` are all high in the same single cycle.
5. `key[0]` held for 40 cycles with the macro defined → pulses at t, t+16, t+20, t+24, ...; with the macro undefined → a single pulse at t.
6. Reset asserted for 1 cycle while `key[0]` is held and repeating → all outputs are 0 the cycle after reset; with the key still held, a new `pulse[0]` appears 6 edges after Reset falls.

Source files
------------

// File: rtl/key_pulse_pkg.sv
// Shared types and default parameter values for the key_pulse_array slice.
package key_pulse_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    HELD_DELAY,
    HELD_REPEAT
  } key_state_t;

  localparam int unsigned KP_N               = 4;
  localparam int unsigned KP_SYNC_STAGES     = 2;
  localparam int unsigned KP_DEBOUNCE_CYCLES = 4;
  localparam int unsigned KP_REPEAT_DELAY    = 16;
  localparam int unsigned KP_REPEAT_PERIOD   = 4;
  localparam logic        KP_ACTIVE_LOW      = 1'b0;

endpackage

// File: rtl/key_pulse_channel.sv
// One key channel: synchroniser, debounce counter and press/repeat FSM.
// Auto-repeat (HELD_REPEAT state and rcnt) exists only with KEY_PULSE_REPEAT_EN.
module key_pulse_channel
  import key_pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = KP_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
`ifdef KEY_PULSE_REPEAT_EN
  parameter int unsigned REPEAT_DELAY    = KP_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = KP_REPEAT_PERIOD,
`endif
  parameter logic        ACTIVE_LOW      = KP_ACTIVE_LOW
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_i,
  output logic pulse_o,
  output logic held_o,
  output logic pulse_d_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DbLast = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   held_q, held_d;
  logic                   pulse_q, pulse_d;
  logic                   synced, accept_rise, accept_fall;
  key_state_t             state_q, state_d;

`ifdef KEY_PULSE_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] DelayLast  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PeriodLast = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rcnt_q, rcnt_d;
`endif

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], key_i ^ ACTIVE_LOW};
    cnt_d       = '0;
    held_d      = held_q;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    if (synced != held_q) begin
      if (cnt_q == DbLast) begin
        held_d      = synced;
        accept_rise = synced;
        accept_fall = ~synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
`ifdef KEY_PULSE_REPEAT_EN
    rcnt_d  = rcnt_q;
`endif
    case (state_q)
      RELEASED: begin
`ifdef KEY_PULSE_REPEAT_EN
        rcnt_d = '0;
`endif
        if (accept_rise) begin
          state_d = HELD_DELAY;
          pulse_d = 1'b1;
        end
      end
      HELD_DELAY: begin
`ifdef KEY_PULSE_REPEAT_EN
        if (rcnt_q == DelayLast) begin
          state_d = HELD_REPEAT;
          pulse_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
`endif
      end
`ifdef KEY_PULSE_REPEAT_EN
      HELD_REPEAT: begin
        if (rcnt_q == PeriodLast) begin
          pulse_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
`endif
      default: state_d = RELEASED;
    endcase
    // Release wins over any repeat strobe falling in the same cycle.
    if (accept_fall) begin
      state_d = RELEASED;
      pulse_d = 1'b0;
`ifdef KEY_PULSE_REPEAT_EN
      rcnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      pulse_q <= 1'b0;
      state_q <= RELEASED;
`ifdef KEY_PULSE_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
`ifdef KEY_PULSE_REPEAT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  assign pulse_o   = pulse_q;
  assign held_o    = held_q;
  assign pulse_d_o = pulse_d;

endmodule

// File: rtl/key_pulse_array.sv
// N-channel key press conditioner; optional auto-repeat under KEY_PULSE_REPEAT_EN.
module key_pulse_array
  import key_pulse_pkg::*;
#(
  parameter int unsigned N               = KP_N,
  parameter int unsigned SYNC_STAGES     = KP_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = KP_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = KP_REPEAT_PERIOD,
  parameter logic        ACTIVE_LOW      = KP_ACTIVE_LOW
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] key,
  output logic [N-1:0] pulse,
  output logic [N-1:0] held,
  output logic         any_pulse
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 ||
      REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_params
    $error("key_pulse_array: illegal parameter combination");
  end

  logic [N-1:0] pulse_next;
  logic         any_pulse_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_pulse_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef KEY_PULSE_REPEAT_EN
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .Clock    (Clock),
      .Reset    (Reset),
      .key_i    (key[i]),
      .pulse_o  (pulse[i]),
      .held_o   (held[i]),
      .pulse_d_o(pulse_next[i])
    );
  end

  // Registered from the channels' next-pulse terms so it lines up with pulse.
  always_ff @(posedge Clock) begin
    if (Reset) any_pulse_q <= 1'b0;
    else       any_pulse_q <= |pulse_next;
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_key_pulse_array.sv
// Directed self-checking bench for key_pulse_array with default parameters.
module tb_key_pulse_array;

  logic       Clock;
  logic       Reset;
  logic [3:0] key;
  logic [3:0] pulse;
  logic [3:0] held;
  logic       any_pulse;

  int unsigned vectors;
  int unsigned miscompares;

`ifdef KEY_PULSE_REPEAT_EN
  localparam logic REPEAT_ON = 1'b1;
`else
  localparam logic REPEAT_ON = 1'b0;
`endif

  key_pulse_array dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .key      (key),
    .pulse    (pulse),
    .held     (held),
    .any_pulse(any_pulse)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic rep;
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b1;
    key         = 4'b0000;

    // 1: reset for two cycles, then idle
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_pulse", pulse, 4'b0000);
      check("rst_held",  held,  4'b0000);
      check("rst_any",   any_pulse, 1'b0);
    end
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("idle_pulse", pulse, 4'b0000);
      check("idle_held",  held,  4'b0000);
      check("idle_any",   any_pulse, 1'b0);
    end

    // 2: single press on key[0], 12 cycles, then release
    key[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("press0_pulse", pulse, (k == 6) ? 4'b0001 : 4'b0000);
      check("press0_held",  held,  (k >= 6) ? 4'b0001 : 4'b0000);
      check("press0_any",   any_pulse, (k == 6) ? 1'b1 : 1'b0);
    end
    key[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("rel0_held",  held,  (k < 6) ? 4'b0001 : 4'b0000);
      check("rel0_pulse", pulse, 4'b0000);
    end

    // 3: glitch of 3 cycles on key[1]
    key[1] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("glitch_held",  held,  4'b0000);
      check("glitch_pulse", pulse, 4'b0000);
    end
    key[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("glitch_held",  held,  4'b0000);
      check("glitch_pulse", pulse, 4'b0000);
      check("glitch_any",   any_pulse, 1'b0);
    end

    // 4: simultaneous press on key[2] and key[3]
    key[3:2] = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("dual_pulse", pulse, (k == 6) ? 4'b1100 : 4'b0000);
      check("dual_held",  held,  (k >= 6) ? 4'b1100 : 4'b0000);
      check("dual_any",   any_pulse, (k == 6) ? 1'b1 : 1'b0);
    end
    key[3:2] = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("dual_rel_held",  held,  (k < 6) ? 4'b1100 : 4'b0000);
      check("dual_rel_pulse", pulse, 4'b0000);
    end

    // 5: long hold on key[0]; repeats only when auto-repeat is built
    key[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      rep = (k == 6) || (REPEAT_ON && k >= 22 && ((k - 22) % 4) == 0);
      check("hold_pulse", pulse, {3'b000, rep});
      check("hold_any",   any_pulse, rep);
      check("hold_held",  held,  (k >= 6) ? 4'b0001 : 4'b0000);
    end

    // 6: one-cycle reset while key[0] is still held
    Reset = 1'b1;
    step();
    check("mid_rst_pulse", pulse, 4'b0000);
    check("mid_rst_held",  held,  4'b0000);
    check("mid_rst_any",   any_pulse, 1'b0);
    Reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("post_rst_pulse", pulse, (k == 6) ? 4'b0001 : 4'b0000);
      check("post_rst_held",  held,  (k >= 6) ? 4'b0001 : 4'b0000);
      check("post_rst_any",   any_pulse, (k == 6) ? 1'b1 : 1'b0);
    end
    key[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("final_rel_held",  held,  (k < 6) ? 4'b0001 : 4'b0000);
      check("final_rel_pulse", pulse, 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
